// File: rtl/out_div_ctrl.sv
// out_div_ctrl: lock-qualified, glitch-free PLL output post-divider with req/ack ratio change
//   i_clk       single clock, rising edge
//   i_rst       synchronous active-low reset
//   i_pll_lock  PLL lock, already synchronised to i_clk
//   i_cfg_div   requested half-period N (0 behaves as 1)
//   i_cfg_req   ratio-change request level, held until o_cfg_ack
//   o_cfg_ack   one-cycle pulse: requested ratio now in effect
//   o_busy      ratio change in progress
//   o_out_en    divided clock running and valid
//   o_out       divided clock, period 2*N, 50 % duty
module out_div_ctrl #(
  parameter int DIV_W      = 8,
  parameter int LOCK_FILT  = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pll_lock,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic             i_cfg_req,
  output logic             o_cfg_ack,
  output logic             o_busy,
  output logic             o_out_en,
  output logic             o_out
);
  localparam int LK_W = $clog2(LOCK_FILT + 1);
  localparam int ST_W = $clog2(SETTLE_CYC + 1);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_FILT - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYC - 1);
  typedef enum logic [1:0] {LOCK_WAIT, RUN, DRAIN, SETTLE} state_t;
  state_t           r_state, w_state;
  logic [DIV_W-1:0] r_hc, w_hc, r_n_act, w_n_act, r_n_pend, w_n_pend, w_div;
  logic [LK_W-1:0]  r_lk, w_lk;
  logic [ST_W-1:0]  r_st, w_st;
  logic             r_out, w_out, r_out_en, w_out_en, r_ack, w_ack, r_busy, w_busy;
  logic             w_acc, w_wrap;
  always_comb begin
    w_div    = (i_cfg_div == '0) ? DIV_W'(1) : i_cfg_div;
    // the ack cycle itself blocks acceptance, giving a 2-cycle minimum request spacing
    w_acc    = i_cfg_req & ~r_busy & ~r_ack;
    w_wrap   = r_hc == r_n_act - DIV_W'(1);
    w_state  = r_state;
    w_hc     = r_hc;
    w_lk     = r_lk;
    w_st     = r_st;
    w_n_act  = r_n_act;
    w_n_pend = r_n_pend;
    w_out    = r_out;
    w_out_en = r_out_en;
    w_ack    = 1'b0;
    w_busy   = r_busy;
    case (r_state)
      LOCK_WAIT: begin
        w_out    = 1'b0;
        w_out_en = 1'b0;
        w_busy   = 1'b0;
        w_lk     = i_pll_lock ? r_lk + LK_W'(1) : '0;
        // no clock is running, so a new ratio can take effect immediately
        if (w_acc) begin
          w_n_act = w_div;
          w_ack   = 1'b1;
        end
        if (i_pll_lock && r_lk == LK_LAST) begin
          w_state  = RUN;
          w_hc     = '0;
          w_out_en = 1'b1;
        end
      end
      RUN, DRAIN: begin
        w_hc  = w_wrap ? '0 : r_hc + DIV_W'(1);
        w_out = r_out ^ w_wrap;
        if (r_state == RUN && w_acc) begin
          w_n_pend = w_div;
          w_busy   = 1'b1;
          w_state  = DRAIN;
        end
        // switch only at the end of a complete high phase so no runt pulse appears
        if (r_state == DRAIN && r_out && w_wrap) begin
          w_out    = 1'b0;
          w_out_en = 1'b0;
          w_n_act  = r_n_pend;
          w_st     = '0;
          w_state  = SETTLE;
        end
      end
      SETTLE: begin
        w_st = r_st + ST_W'(1);
        if (r_st == ST_LAST) begin
          w_state  = RUN;
          w_hc     = '0;
          w_busy   = 1'b0;
          w_ack    = 1'b1;
          w_out_en = 1'b1;
        end
      end
    endcase
    // lock loss overrides everything; a pending change completes so the requester never hangs
    if (r_state != LOCK_WAIT && !i_pll_lock) begin
      w_state  = LOCK_WAIT;
      w_out    = 1'b0;
      w_out_en = 1'b0;
      w_lk     = '0;
      w_ack    = r_busy;
      w_busy   = 1'b0;
      w_n_act  = r_busy ? r_n_pend : r_n_act;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= LOCK_WAIT;
      r_hc     <= '0;
      r_lk     <= '0;
      r_st     <= '0;
      r_n_act  <= DIV_W'(1);
      r_n_pend <= DIV_W'(1);
      r_out    <= 1'b0;
      r_out_en <= 1'b0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_hc     <= w_hc;
      r_lk     <= w_lk;
      r_st     <= w_st;
      r_n_act  <= w_n_act;
      r_n_pend <= w_n_pend;
      r_out    <= w_out;
      r_out_en <= w_out_en;
      r_ack    <= w_ack;
      r_busy   <= w_busy;
    end
  end
  assign o_out     = r_out;
  assign o_out_en  = r_out_en;
  assign o_cfg_ack = r_ack;
  assign o_busy    = r_busy;
endmodule

// File: tb/tb_out_div_ctrl.sv
// tb_out_div_ctrl: directed and randomized checks of out_div_ctrl against a phase-timing model
module tb_out_div_ctrl;
  localparam int LF = 16;
  localparam int SC = 4;
  localparam int MW = 0, MR = 1, MD = 2, MS = 3;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lock = 1'b0;
  logic       req = 1'b0;
  logic [7:0] div = 8'd0;
  logic       ack, busy, en, out;
  int         checks = 0;
  int         failures = 0;
  bit         chk_en = 1'b0;
  always #5 clk = ~clk;
  out_div_ctrl #(.DIV_W(8), .LOCK_FILT(LF), .SETTLE_CYC(SC)) dut (
    .i_clk(clk), .i_rst(rst), .i_pll_lock(lock), .i_cfg_div(div), .i_cfg_req(req),
    .o_cfg_ack(ack), .o_busy(busy), .o_out_en(en), .o_out(out)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask
  // model: time-to-next-toggle countdowns rather than up-counters
  int m_mode = MW, m_lrun = 0, m_left = 0, m_sleft = 0, m_n = 1, m_pend = 1;
  bit m_out = 0, m_en = 0, m_ack = 0, m_busy = 0;
  always @(posedge clk) begin
    bit acc;
    int d;
    acc = req && !m_busy && !m_ack;
    d = (div == 0) ? 1 : int'(div);
    if (!rst) begin
      m_mode = MW; m_out = 0; m_en = 0; m_ack = 0; m_busy = 0; m_n = 1; m_lrun = 0;
    end else if (m_mode != MW && !lock) begin
      m_mode = MW; m_out = 0; m_en = 0; m_lrun = 0; m_ack = m_busy;
      if (m_busy) m_n = m_pend;
      m_busy = 0;
    end else if (m_mode == MW) begin
      m_ack = acc;
      if (acc) m_n = d;
      m_lrun = lock ? m_lrun + 1 : 0;
      if (m_lrun == LF) begin m_mode = MR; m_en = 1; m_left = m_n; end
    end else if (m_mode == MS) begin
      m_ack = 0;
      m_sleft--;
      if (m_sleft == 0) begin m_mode = MR; m_en = 1; m_busy = 0; m_ack = 1; m_left = m_n; end
    end else begin
      bit was_run;
      was_run = m_mode == MR;
      m_ack = 0;
      m_left--;
      if (m_left == 0) begin
        if (m_mode == MD && m_out) begin
          m_out = 0; m_n = m_pend; m_mode = MS; m_sleft = SC; m_en = 0;
        end else begin
          m_out = !m_out; m_left = m_n;
        end
      end
      if (was_run && acc) begin m_pend = d; m_busy = 1; m_mode = MD; end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out", out, m_out);
      chk("model_out_en", en, m_en);
      chk("model_ack", ack, m_ack);
      chk("model_busy", busy, m_busy);
    end
  end
  task automatic wait_en(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!en && n < 40);
  endtask
  task automatic high_len(output int len);
    int t = 0;
    while (!out && t < 40) begin @(negedge clk); t++; end
    len = 0;
    while (out && len < 40) begin @(negedge clk); len++; end
  endtask
  task automatic low_len(output int len);
    int t = 0;
    while (out && t < 40) begin @(negedge clk); t++; end
    len = 0;
    while (!out && len < 40) begin @(negedge clk); len++; end
  endtask
  task automatic wait_ack();
    int t = 0;
    while (!ack && t < 60) begin @(negedge clk); t++; end
    chk("ack_arrives", ack, 1);
    req = 0;
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_out", out, 0);
    chk("rst_en", en, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    rst = 1; lock = 1;
    wait_en(n);
    chk("lock_filter_edges", n, 16);
    chk("run_entry_out", out, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("div2_toggle", out, (i % 2 == 0) ? 1 : 0);
    end
    lock = 0;
    @(negedge clk);
    chk("lockloss_en", en, 0);
    lock = 1;
    repeat (10) @(negedge clk);
    lock = 0;
    @(negedge clk);
    lock = 1;
    wait_en(n);
    chk("lock_restart_edges", n, 16);
    req = 1; div = 3;
    @(negedge clk);
    chk("n3_busy_next", busy, 1);
    wait_ack();
    high_len(n);
    chk("n3_high", n, 3);
    low_len(n);
    chk("n3_low", n, 3);
    lock = 0;
    @(negedge clk);
    req = 1; div = 0;
    @(negedge clk);
    chk("div0_ack", ack, 1);
    chk("div0_busy", busy, 0);
    req = 0; lock = 1;
    wait_en(n);
    chk("div0_lock_edges", n, 16);
    high_len(n);
    chk("div0_high", n, 1);
    lock = 0;
    @(negedge clk);
    req = 1; div = 4;
    @(negedge clk);
    chk("n4_ack_wait", ack, 1);
    req = 0; lock = 1;
    wait_en(n);
    repeat (3) @(negedge clk);
    req = 1; div = 2;
    @(negedge clk);
    chk("drain_busy", busy, 1);
    @(negedge clk);
    lock = 0;
    @(negedge clk);
    chk("drain_loss_out", out, 0);
    chk("drain_loss_en", en, 0);
    chk("drain_loss_ack", ack, 1);
    chk("drain_loss_busy", busy, 0);
    req = 0; lock = 1;
    wait_en(n);
    chk("drain_relock_edges", n, 16);
    high_len(n);
    chk("n2_high", n, 2);
    low_len(n);
    chk("n2_low", n, 2);
    req = 1; div = 5;
    n = 0;
    do begin @(negedge clk); n++; end while (!(busy && !en) && n < 40);
    chk("settle_reached", busy && !en, 1);
    rst = 0;
    @(negedge clk);
    chk("rst_settle_busy", busy, 0);
    chk("rst_settle_ack", ack, 0);
    chk("rst_settle_en", en, 0);
    chk("rst_settle_out", out, 0);
    rst = 1; req = 0;
    wait_en(n);
    chk("rst_relock_edges", n, 16);
    high_len(n);
    chk("rst_n1_high", n, 1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (req && ack) req = 0;
      else if (!req && $urandom_range(0, 15) == 0) begin
        req = 1;
        div = 8'($urandom_range(0, 6));
      end
      lock = ($urandom_range(0, 299) != 0);
      rst = ($urandom_range(0, 1499) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
